// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_ctrl_pkg
// Description : Shared definitions for the register-file/ALU datapath and the
//               control units that drive it: control-bundle field widths,
//               arbiter state encoding and small index helpers.
// Contents    : CONST_W/INMUX_W/OUTMUX_W/REGADD_W/INSSEL_W - bundle widths
//               MAX_REQ/IDX_W/HOLD_W - arbiter sizing
//               arb_state_t - arbiter FSM state
//               idx_onehot() - unit index to one-hot vector
// Revision    : 1.0 - initial release
// ============================================================================
package dp_ctrl_pkg;

    // Control-bundle field widths shared by every control unit.
    localparam int CONST_W  = 8;
    localparam int INMUX_W  = 3;
    localparam int OUTMUX_W = 4;
    localparam int REGADD_W = 4;
    localparam int INSSEL_W = 2;

    // Arbiter sizing: at most four requesters, so unit indices fit in 2 bits.
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // One-hot of a unit index over the full MAX_REQ range; callers slice it
    // down to their own request count.
    function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage : dp_ctrl_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder. Returns the first
//               set bit of eligible, searching upward from rr_ptr and
//               wrapping around at NUM_REQ.
// Ports       : eligible - candidate vector (NUM_REQ bits)
//               rr_ptr   - index where the search starts
//               sel      - index of the chosen candidate (0 when none)
//               valid    - at least one candidate was set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import dp_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   sel,
    output logic               valid
);

    // Eligible vector widened to the full index range so any 2-bit index can
    // address it without a width mismatch for small NUM_REQ.
    logic [MAX_REQ-1:0] w_elig_ext;
    logic [IDX_W-1:0]   w_idx [NUM_REQ];
    logic [IDX_W-1:0]   w_sel;
    logic               w_found;

    assign w_elig_ext = MAX_REQ'(eligible);

    // w_idx[k] is the unit examined at search position k: (rr_ptr + k) mod NUM_REQ.
    // rr_ptr is always below NUM_REQ, so a single conditional subtract wraps it.
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_rot
            logic [IDX_W:0] w_sum;
            assign w_sum    = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            assign w_idx[k] = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                              IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) :
                              w_sum[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_elig_ext[w_idx[k]]) begin
                w_sel   = w_idx[k];
                w_found = 1'b1;
            end
        end
    end

    assign sel   = w_sel;
    assign valid = w_found;

endmodule : rr_pick
`default_nettype wire

// File: rtl/datapath_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : datapath_arbiter
// Description : Shares one register-file/ALU datapath between NUM_REQ
//               sequencing control units. Round-robin grant held for a whole
//               operation, one dead RELEASE cycle between owners, and a hold
//               watchdog that revokes a grant held for MAX_HOLD cycles.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               req / gnt       - per-unit request (level) / one-hot grant
//               req_*           - per-unit control bundles, flattened
//               dp_*            - owner's bundle to the datapath (0 when idle)
//               dp_co, dp_z     - ALU flags from the datapath
//               flag_co, flag_z - ALU flags broadcast to all units
//               busy            - a unit currently owns the datapath
//               timeout         - one-cycle pulse when the watchdog fires
//               owner           - index of the current or last owner
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_arbiter
    import dp_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CW       = CONST_W,
    parameter int MAX_HOLD = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic [NUM_REQ*CW-1:0]        req_const,
    input  logic [NUM_REQ*INMUX_W-1:0]   req_inmux,
    input  logic [NUM_REQ*OUTMUX_W-1:0]  req_outmux,
    input  logic [NUM_REQ*REGADD_W-1:0]  req_regadd,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*INSSEL_W-1:0]  req_inssel,
    output logic [CW-1:0]                dp_const,
    output logic [INMUX_W-1:0]           dp_inmux,
    output logic [OUTMUX_W-1:0]          dp_outmux,
    output logic [REGADD_W-1:0]          dp_regadd,
    output logic                         dp_we,
    output logic [INSSEL_W-1:0]          dp_inssel,
    input  logic                         dp_co,
    input  logic                         dp_z,
    output logic                         flag_co,
    output logic                         flag_z,
    output logic                         busy,
    output logic                         timeout,
    output logic [IDX_W-1:0]             owner
);

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_blocked;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic                 r_timeout;

    // ------------------------------------------------------------------
    // Per-unit bundles unpacked into arrays padded to MAX_REQ entries so the
    // 2-bit owner index can select from them directly.
    // ------------------------------------------------------------------
    logic [CW-1:0]        w_const_arr  [MAX_REQ];
    logic [INMUX_W-1:0]   w_inmux_arr  [MAX_REQ];
    logic [OUTMUX_W-1:0]  w_outmux_arr [MAX_REQ];
    logic [REGADD_W-1:0]  w_regadd_arr [MAX_REQ];
    logic [INSSEL_W-1:0]  w_inssel_arr [MAX_REQ];
    logic [MAX_REQ-1:0]   w_req_ext;
    logic [MAX_REQ-1:0]   w_we_ext;

    assign w_req_ext = MAX_REQ'(req);
    assign w_we_ext  = MAX_REQ'(req_we);

    generate
        for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
            if (i < NUM_REQ) begin : g_live
                assign w_const_arr[i]  = req_const[i*CW +: CW];
                assign w_inmux_arr[i]  = req_inmux[i*INMUX_W +: INMUX_W];
                assign w_outmux_arr[i] = req_outmux[i*OUTMUX_W +: OUTMUX_W];
                assign w_regadd_arr[i] = req_regadd[i*REGADD_W +: REGADD_W];
                assign w_inssel_arr[i] = req_inssel[i*INSSEL_W +: INSSEL_W];
            end else begin : g_pad
                assign w_const_arr[i]  = '0;
                assign w_inmux_arr[i]  = '0;
                assign w_outmux_arr[i] = '0;
                assign w_regadd_arr[i] = '0;
                assign w_inssel_arr[i] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration: units revoked by the watchdog stay out until they drop req.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]   w_eligible;
    logic [IDX_W-1:0]     w_pick_sel;
    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_rr_next;
    logic [MAX_REQ-1:0]   w_sel_oh_ext;
    logic [MAX_REQ-1:0]   w_owner_oh_ext;

    assign w_eligible = req & ~r_blocked;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .sel      (w_pick_sel),
        .valid    (w_pick_valid)
    );

    assign w_rr_next      = (w_pick_sel == c_last_idx) ? '0 : w_pick_sel + IDX_W'(1);
    assign w_sel_oh_ext   = idx_onehot(w_pick_sel);
    assign w_owner_oh_ext = idx_onehot(r_owner);

    // ------------------------------------------------------------------
    // Grant termination conditions. A req drop on the expiry cycle wins, so
    // w_expire requires the owner to still be requesting.
    // ------------------------------------------------------------------
    logic w_in_grant;
    logic w_owner_req;
    logic w_expire;

    assign w_in_grant  = (r_state == ARB_GRANT);
    assign w_owner_req = w_req_ext[r_owner];
    assign w_expire    = w_in_grant && w_owner_req && (r_hold_cnt == c_hold_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!w_owner_req || w_expire) begin
                    w_state_nxt = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_blocked  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            // A block is cleared by any cycle in which the unit's req is low.
            r_blocked <= (r_blocked & req) |
                         (w_expire ? w_owner_oh_ext[NUM_REQ-1:0] : '0);

            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_gnt      <= w_sel_oh_ext[NUM_REQ-1:0];
                        r_owner    <= w_pick_sel;
                        r_rr_ptr   <= w_rr_next;
                        r_hold_cnt <= '0;
                    end
                end
                ARB_GRANT: begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    if (!w_owner_req || w_expire) begin
                        r_gnt <= '0;
                    end
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The datapath sees the owner's bundle only in GRANT; in
    // RELEASE and IDLE everything (notably dp_we) is forced to zero so the
    // outgoing owner's last write cannot overlap the next owner's first.
    // ------------------------------------------------------------------
    always_comb begin
        busy      = w_in_grant;
        dp_const  = '0;
        dp_inmux  = '0;
        dp_outmux = '0;
        dp_regadd = '0;
        dp_we     = 1'b0;
        dp_inssel = '0;
        if (w_in_grant) begin
            dp_const  = w_const_arr[r_owner];
            dp_inmux  = w_inmux_arr[r_owner];
            dp_outmux = w_outmux_arr[r_owner];
            dp_regadd = w_regadd_arr[r_owner];
            dp_we     = w_we_ext[r_owner];
            dp_inssel = w_inssel_arr[r_owner];
        end
    end

    assign gnt     = r_gnt;
    assign timeout = r_timeout;
    assign owner   = r_owner;

    // Flags go to every unit ungated; a unit without gnt ignores them.
    assign flag_co = dp_co;
    assign flag_z  = dp_z;

endmodule : datapath_arbiter
`default_nettype wire

// File: tb/tb_datapath_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_arbiter
// Description : Self-checking bench for datapath_arbiter (NUM_REQ=2, CW=8,
//               MAX_HOLD=8): a table of single-cycle vectors plus directed
//               sequences for fairness, watchdog, async reset and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [15:0] req_const;
    logic [5:0]  req_inmux;
    logic [7:0]  req_outmux;
    logic [7:0]  req_regadd;
    logic [1:0]  req_we;
    logic [3:0]  req_inssel;
    logic [7:0]  dp_const;
    logic [2:0]  dp_inmux;
    logic [3:0]  dp_outmux;
    logic [3:0]  dp_regadd;
    logic        dp_we;
    logic [1:0]  dp_inssel;
    logic        dp_co;
    logic        dp_z;
    logic        flag_co;
    logic        flag_z;
    logic        busy;
    logic        timeout;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    datapath_arbiter #(
        .NUM_REQ  (2),
        .CW       (8),
        .MAX_HOLD (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .req_const  (req_const),
        .req_inmux  (req_inmux),
        .req_outmux (req_outmux),
        .req_regadd (req_regadd),
        .req_we     (req_we),
        .req_inssel (req_inssel),
        .dp_const   (dp_const),
        .dp_inmux   (dp_inmux),
        .dp_outmux  (dp_outmux),
        .dp_regadd  (dp_regadd),
        .dp_we      (dp_we),
        .dp_inssel  (dp_inssel),
        .dp_co      (dp_co),
        .dp_z       (dp_z),
        .flag_co    (flag_co),
        .flag_z     (flag_z),
        .busy       (busy),
        .timeout    (timeout),
        .owner      (owner)
    );

    // All observable outputs except the flags, in one word.
    logic [27:0] w_act;
    assign w_act = {gnt, busy, timeout, owner, dp_const, dp_inmux,
                    dp_outmux, dp_regadd, dp_we, dp_inssel};

    // Expected output word. Bundle fields come from the fixed per-unit
    // constants driven below; regadd and we are given by the caller.
    function automatic logic [27:0] exp_out(input logic [1:0] g, input logic b,
                                            input logic t, input logic [1:0] o,
                                            input logic [3:0] ra, input logic we);
        logic [7:0] c;
        logic [2:0] im;
        logic [3:0] om;
        logic [1:0] is;
        c = 8'h00; im = 3'd0; om = 4'd0; is = 2'd0;
        if (b && o == 2'd0) begin
            c = 8'hA5; im = 3'd1; om = 4'd2; is = 2'd1;
        end else if (b) begin
            c = 8'h5A; im = 3'd6; om = 4'd9; is = 2'd2;
        end
        return {g, b, t, o, c, im, om, ra, we, is};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        req    = 2'b00;
        req_we = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [1:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic [3:0] regadd;
        logic       dp_we;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        logic [1:0] oh;
        int         e;

        //            req    we     gnt    busy  owner regadd dp_we
        vecs[0]  = '{2'b01, 2'b11, 2'b01, 1'b1, 2'd0, 4'd3,  1'b1}; // grant latency 1
        vecs[1]  = '{2'b01, 2'b10, 2'b01, 1'b1, 2'd0, 4'd3,  1'b0}; // non-owner we/regadd ignored
        vecs[2]  = '{2'b00, 2'b11, 2'b00, 1'b0, 2'd0, 4'd0,  1'b0}; // drop -> RELEASE
        vecs[3]  = '{2'b00, 2'b11, 2'b00, 1'b0, 2'd0, 4'd0,  1'b0}; // IDLE
        vecs[4]  = '{2'b11, 2'b11, 2'b10, 1'b1, 2'd1, 4'd14, 1'b1}; // rr_ptr=1 -> unit1
        vecs[5]  = '{2'b11, 2'b01, 2'b10, 1'b1, 2'd1, 4'd14, 1'b0}; // non-owner we ignored
        vecs[6]  = '{2'b01, 2'b11, 2'b00, 1'b0, 2'd1, 4'd0,  1'b0}; // RELEASE
        vecs[7]  = '{2'b01, 2'b11, 2'b00, 1'b0, 2'd1, 4'd0,  1'b0}; // IDLE, waiting
        vecs[8]  = '{2'b01, 2'b11, 2'b01, 1'b1, 2'd0, 4'd3,  1'b1}; // unit0 granted
        vecs[9]  = '{2'b00, 2'b11, 2'b00, 1'b0, 2'd0, 4'd0,  1'b0};
        vecs[10] = '{2'b00, 2'b11, 2'b00, 1'b0, 2'd0, 4'd0,  1'b0};

        rst        = 1'b1;
        req        = 2'b11;
        req_we     = 2'b11;
        req_const  = {8'h5A, 8'hA5};
        req_inmux  = {3'd6, 3'd1};
        req_outmux = {4'd9, 4'd2};
        req_regadd = {4'd14, 4'd3};
        req_inssel = {2'd2, 2'd1};
        dp_co      = 1'b0;
        dp_z       = 1'b0;

        // Reset state, with requests present
        repeat (2) @(posedge clk);
        #1;
        check("reset", 32'(w_act), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req    = vecs[i].req;
            req_we = vecs[i].we;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(w_act),
                  32'(exp_out(vecs[i].gnt, vecs[i].busy, 1'b0, vecs[i].owner,
                              vecs[i].regadd, vecs[i].dp_we)));
        end

        // Simultaneous requests after reset, then fairness 0,1,0,1
        do_reset();
        req = 2'b11;
        @(posedge clk);
        #1;
        for (int op = 0; op < 4; op++) begin
            e  = op % 2;
            oh = (e == 0) ? 2'b01 : 2'b10;
            check($sformatf("fair_gnt%0d", op), {28'd0, gnt, owner}, {28'd0, oh, 2'(e)});
            @(negedge clk);
            @(posedge clk);
            #1;
            @(negedge clk);
            req = ~oh;
            @(posedge clk);
            #1;
            check($sformatf("fair_release%0d", op), {29'd0, gnt, busy, dp_we}, 32'd0);
            @(negedge clk);
            req = 2'b11;
            @(posedge clk);
            #1;
            check($sformatf("fair_idle%0d", op), {30'd0, gnt, busy}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Watchdog: unit0 holds for MAX_HOLD cycles
        do_reset();
        req = 2'b01;
        @(posedge clk);
        #1;
        check("wd_grant", {30'd0, gnt}, 32'h1);
        @(negedge clk);
        req = 2'b11;
        repeat (7) @(posedge clk);
        #1;
        check("wd_hold", {29'd0, gnt, timeout}, {29'd0, 2'b01, 1'b0});
        @(posedge clk);
        #1;
        check("wd_timeout", {28'd0, gnt, busy, timeout}, {28'd0, 2'b00, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        check("wd_pulse", {31'd0, timeout}, 32'd0);
        @(posedge clk);
        #1;
        check("wd_next", {28'd0, gnt, owner}, {28'd0, 2'b10, 2'd1});
        @(negedge clk);
        req = 2'b01;
        repeat (4) @(posedge clk);
        #1;
        check("wd_blocked", {29'd0, gnt, busy}, 32'd0);
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        req = 2'b01;
        @(posedge clk);
        #1;
        check("wd_regrant", {30'd0, gnt}, 32'h1);

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 2'b01;
        @(posedge clk);
        #1;
        check("arst_pre", {30'd0, gnt}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst", 32'(w_act), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b10;
        @(posedge clk);
        #1;
        check("arst_regrant", {28'd0, gnt, owner}, {28'd0, 2'b10, 2'd1});

        // Flag pass-through, independent of grant
        dp_co = 1'b1;
        dp_z  = 1'b0;
        #1;
        check("flags_co", {30'd0, flag_co, flag_z}, 32'h2);
        dp_co = 1'b0;
        dp_z  = 1'b1;
        #1;
        check("flags_z", {30'd0, flag_co, flag_z}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_datapath_arbiter
`default_nettype wire
